// File: rtl/transmitter_if.sv
// rtl/transmitter_if.sv - host-side handshake bundle for the UART transmit engine
interface transmitter_if #(
    parameter int data_width = 8
);
    logic                  tx_start;
    logic [data_width-1:0] tx_data;
    logic                  parity_en;
    logic                  odd_or_even_parity;
    logic                  busy;
    logic                  done;

    modport master (
        output tx_start,
        output tx_data,
        output parity_en,
        output odd_or_even_parity,
        input  busy,
        input  done
    );

    modport slave (
        input  tx_start,
        input  tx_data,
        input  parity_en,
        input  odd_or_even_parity,
        output busy,
        output done
    );
endinterface

// File: rtl/transmitter.sv
// rtl/transmitter.sv - UART transmit engine: start, LSB-first data, optional parity, one stop bit
module transmitter #(
    parameter int data_width = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tx_tick,
    output logic          tx,
    transmitter_if.slave  bus
);
    localparam int bw = (data_width > 1) ? $clog2(data_width) : 1;
    localparam logic [bw-1:0] last_bit = bw'(data_width - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state, state_n;
    logic [3:0]            tick_count, tick_count_n;
    logic [bw-1:0]         bit_count, bit_count_n;
    logic [data_width-1:0] shreg, shreg_n;
    logic                  par_en_q, par_en_n;
    logic                  par_bit_q, par_bit_n;
    logic                  tx_q, tx_n;
    logic                  busy_q, busy_n;
    logic                  done_q, done_n;

    assign tx       = tx_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

    // State, counters, hold register and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            tick_count <= '0;
            bit_count  <= '0;
            shreg      <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state      <= state_n;
            tick_count <= tick_count_n;
            bit_count  <= bit_count_n;
            shreg      <= shreg_n;
            par_en_q   <= par_en_n;
            par_bit_q  <= par_bit_n;
            tx_q       <= tx_n;
            busy_q     <= busy_n;
            done_q     <= done_n;
        end
    end

    // Next-state and output decode; every bit boundary lands on the 16th tick
    always_comb begin
        state_n      = state;
        tick_count_n = tick_count;
        bit_count_n  = bit_count;
        shreg_n      = shreg;
        par_en_n     = par_en_q;
        par_bit_n    = par_bit_q;
        tx_n         = tx_q;
        busy_n       = busy_q;
        done_n       = 1'b0;

        case (state)
            IDLE: begin
                tx_n   = 1'b1;
                busy_n = 1'b0;
                // Acceptance does not wait for a tick; the start bit is
                // stretched by at most one tick period, which the receiver tolerates.
                if (bus.tx_start) begin
                    shreg_n      = bus.tx_data;
                    par_en_n     = bus.parity_en;
                    // 1 selects even total ones (parity = xor), 0 selects odd
                    par_bit_n    = bus.odd_or_even_parity ? ^bus.tx_data : ~^bus.tx_data;
                    state_n      = START;
                    tx_n         = 1'b0;
                    busy_n       = 1'b1;
                    tick_count_n = '0;
                    bit_count_n  = '0;
                end
            end

            START, DATA, PARITY, STOP: begin
                if (tx_tick) begin
                    if (tick_count == 4'd15) begin
                        tick_count_n = '0;
                        case (state)
                            START: begin
                                state_n = DATA;
                                tx_n    = shreg[0];
                            end
                            DATA: begin
                                if (bit_count == last_bit) begin
                                    if (par_en_q) begin
                                        state_n = PARITY;
                                        tx_n    = par_bit_q;
                                    end else begin
                                        state_n = STOP;
                                        tx_n    = 1'b1;
                                    end
                                end else begin
                                    // Shifting keeps the next bit at position 1,
                                    // i.e. data[bit_count+1] of the latched word
                                    bit_count_n = bit_count + 1'b1;
                                    shreg_n     = {1'b0, shreg[data_width-1:1]};
                                    tx_n        = shreg[1];
                                end
                            end
                            PARITY: begin
                                state_n = STOP;
                                tx_n    = 1'b1;
                            end
                            default: begin
                                state_n = IDLE;
                                tx_n    = 1'b1;
                                busy_n  = 1'b0;
                                done_n  = 1'b1;
                            end
                        endcase
                    end else begin
                        tick_count_n = tick_count + 4'd1;
                    end
                end
            end

            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
                busy_n  = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_transmitter.sv
// tb/tb_transmitter.sv - randomized self-checking bench for the UART transmit engine
module tb_transmitter;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic tx_tick = 1'b0;
    logic tx;

    transmitter_if #(.data_width(W)) bus ();

    transmitter #(.data_width(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .tx_tick (tx_tick),
        .tx      (tx),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Even selection (1) gives an even total number of ones over data+parity
    function automatic logic ref_parity(input logic [W-1:0] d, input logic oe);
        int ones;
        ones = $countones(d);
        return oe ? ((ones % 2) == 1) : ((ones % 2) == 0);
    endfunction

    task automatic tick();
        @(negedge clk) tx_tick = 1'b1;
        @(negedge clk) tx_tick = 1'b0;
    endtask

    task automatic start_frame(input logic [W-1:0] d, input logic pe, input logic oe);
        bus.tx_data            = d;
        bus.parity_en          = pe;
        bus.odd_or_even_parity = oe;
        bus.tx_start           = 1'b1;
        @(negedge clk);
        bus.tx_start           = 1'b0;
        bus.tx_data            = W'($urandom);
        bus.parity_en          = 1'($urandom);
        bus.odd_or_even_parity = 1'($urandom);
        check("start_tx", tx, 0);
        check("start_busy", bus.busy, 1);
        check("start_done", bus.done, 0);
    endtask

    // Plays one frame tick by tick against the expected bit list; ends in the done cycle
    task automatic play_frame(input logic [W-1:0] d, input logic pe, input logic oe,
                              input int intrude_at, output logic par_seen);
        logic     exp_bits[$];
        logic     mid[$];
        logic [W-1:0] rx_d;
        int       n;
        int       ones;
        exp_bits.push_back(1'b0);
        for (int i = 0; i < W; i++) exp_bits.push_back(d[i]);
        if (pe) exp_bits.push_back(ref_parity(d, oe));
        exp_bits.push_back(1'b1);
        n = exp_bits.size();
        for (int k = 1; k <= 16 * n; k++) begin
            tick();
            if ((k % 16) == 8) mid.push_back(tx);
            if (k < 16 * n) begin
                check("bit_tx", tx, exp_bits[k / 16]);
                check("frame_busy", bus.busy, 1);
                check("frame_done", bus.done, 0);
                if (k == intrude_at) begin
                    bus.tx_start           = 1'b1;
                    bus.tx_data            = W'($urandom);
                    bus.parity_en          = ~pe;
                    bus.odd_or_even_parity = ~oe;
                    @(negedge clk);
                    bus.tx_start           = 1'b0;
                    check("intrude_busy", bus.busy, 1);
                    check("intrude_tx", tx, exp_bits[k / 16]);
                end else begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
            end else begin
                check("end_done", bus.done, 1);
                check("end_busy", bus.busy, 0);
                check("end_tx", tx, 1);
            end
        end
        // Mid-bit samples form a simple loopback receiver
        rx_d = '0;
        for (int i = 0; i < W; i++) rx_d[i] = mid[1 + i];
        check("rx_start", mid[0], 0);
        check("rx_stop", mid[n - 1], 1);
        check("rx_data", rx_d, d);
        par_seen = pe ? mid[W + 1] : 1'b0;
        if (pe) begin
            ones = $countones(rx_d) + int'(par_seen);
            check("rx_parity_ok", (ones % 2), oe ? 0 : 1);
        end
    endtask

    task automatic do_frame(input logic [W-1:0] d, input logic pe, input logic oe,
                            input int intrude_at, output logic par_seen);
        start_frame(d, pe, oe);
        play_frame(d, pe, oe, intrude_at, par_seen);
    endtask

    task automatic finish_idle();
        @(negedge clk);
        check("post_done", bus.done, 0);
        check("post_busy", bus.busy, 0);
        check("post_tx", tx, 1);
    endtask

    logic par;

    initial begin
        bus.tx_start           = 1'b0;
        bus.tx_data            = '0;
        bus.parity_en          = 1'b0;
        bus.odd_or_even_parity = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        rst = 1'b1;

        for (int i = 0; i < 50; i++) begin
            tick();
            check("idle_tx", tx, 1);
            check("idle_busy", bus.busy, 0);
            check("idle_done", bus.done, 0);
        end

        do_frame(8'hA5, 1'b0, 1'b0, -1, par);
        finish_idle();
        do_frame(8'h07, 1'b1, 1'b1, -1, par);
        check("par_07_even", par, 1);
        finish_idle();
        do_frame(8'h07, 1'b1, 1'b0, -1, par);
        check("par_07_odd", par, 0);
        finish_idle();
        do_frame(8'hA5, 1'b1, 1'b1, -1, par);
        check("par_a5_even", par, 0);
        finish_idle();
        do_frame(8'hA5, 1'b1, 1'b0, -1, par);
        check("par_a5_odd", par, 1);
        finish_idle();

        do_frame(8'h11, 1'b0, 1'b1, 16 * 3 + 4, par);
        finish_idle();
        for (int i = 0; i < 20; i++) begin
            tick();
            check("no_3c_tx", tx, 1);
            check("no_3c_busy", bus.busy, 0);
        end

        // Back-to-back: the 0x55 start lands in the done cycle
        do_frame(8'h3C, 1'b1, 1'b1, -1, par);
        do_frame(8'h55, 1'b0, 1'b0, -1, par);
        finish_idle();

        start_frame(8'hF0, 1'b1, 1'b1);
        for (int k = 0; k < 16 * 3 + 5; k++) tick();
        rst = 1'b0;
        #1;
        check("midrst_tx", tx, 1);
        check("midrst_busy", bus.busy, 0);
        check("midrst_done", bus.done, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("inrst_tx", tx, 1);
        end
        @(negedge clk) rst = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick();
            check("afterrst_tx", tx, 1);
            check("afterrst_done", bus.done, 0);
            check("afterrst_busy", bus.busy, 0);
        end

        for (int f = 0; f < 16; f++) begin
            logic [W-1:0] d;
            logic pe, oe;
            int   intr;
            d    = W'($urandom);
            pe   = 1'($urandom);
            oe   = 1'($urandom);
            intr = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 16 * 10 - 1)) : -1;
            do_frame(d, pe, oe, intr, par);
            if ($urandom_range(0, 1) == 1) begin
                finish_idle();
                repeat ($urandom_range(0, 3)) begin
                    tick();
                    check("gap_tx", tx, 1);
                end
            end
        end
        finish_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
